// File: rtl/tile_line_fetcher_pkg.sv
// tile_line_fetcher_pkg: tile geometry, map-entry fields and fetch state encoding
package tile_line_fetcher_pkg;
    localparam int TILE_W        = 16;
    localparam int WORDS_PER_ROW = 8;
    localparam int IDX_W         = 9;
    localparam int ROW_W         = 4;
    localparam int WORD_W        = 3;
    localparam int ADDR_W        = 23;
    localparam int MAP_IDX_LSB   = 0;
    localparam int MAP_IDX_MSB   = MAP_IDX_LSB + IDX_W - 1;

    typedef enum logic [2:0] {
        IDLE, MAP_REQ, MAP_WAIT, PIX_REQ, PIX_WAIT, WR_LO, WR_HI, DRAIN
    } state_e;
endpackage

// File: rtl/tile_line_fetcher.sv
// tile_line_fetcher: walks the tile map and tile pixels in SDRAM to fill one scanline of palette indexes
module tile_line_fetcher
    import tile_line_fetcher_pkg::*;
#(
    parameter int H_PIXELS = 640,
    parameter int LB_AW    = 10
) (
    input  logic              MemClk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] BaseAddress,
    input  logic [15:0]       DeltaAddress,
    input  logic [ADDR_W-1:0] TileAddress,
    input  logic [3:0]        Xoffset,
    input  logic [3:0]        Yoffset,
    input  logic              LineStart,
    input  logic [9:0]        LineNum,
    output logic              Rd_Req,
    output logic [ADDR_W-1:0] Rd_Address,
    input  logic              Rd_Ack,
    input  logic              Rd_Valid,
    input  logic [15:0]       Rd_Data,
    output logic              LB_wren,
    output logic [LB_AW-1:0]  LB_wraddress,
    output logic [7:0]        LB_data,
    output logic              Busy,
    output logic              LineDone,
    output logic              Overrun
);
    localparam int TILES = H_PIXELS / TILE_W + 1;
    localparam int TX_W  = $clog2(TILES);
    localparam int P_W   = TX_W + $clog2(TILE_W) + 1;
    localparam logic [TX_W-1:0]   TX_LAST   = TX_W'(TILES - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS_PER_ROW - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   map_row_q, map_row_d;
    logic [15:0]         delta_q, delta_d;
    logic [ADDR_W-1:0]   tile_addr_q, tile_addr_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [3:0]          xoff_q, xoff_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [WORD_W-1:0]   w_q, w_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         data_q, data_d;
    logic                overrun_q, overrun_d;
    logic                line_done_q, line_done_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                lb_wren_q, lb_wren_d;
    logic [LB_AW-1:0]    lb_addr_q, lb_addr_d;
    logic [7:0]          lb_data_q, lb_data_d;
    logic                busy_q, busy_d;
    logic                in_flight;
    logic [P_W-1:0]      pix;
    logic                in_win;

    // a read is still owed to us if we are waiting on data or the request is being accepted right now
    assign in_flight = ((state_q == MAP_WAIT || state_q == PIX_WAIT || state_q == DRAIN) && !Rd_Valid)
                     || (rd_req_q && Rd_Ack);

    assign Rd_Req       = rd_req_q;
    assign Rd_Address   = rd_addr_q;
    assign LB_wren      = lb_wren_q;
    assign LB_wraddress = lb_addr_q;
    assign LB_data      = lb_data_q;
    assign Busy         = busy_q;
    assign LineDone     = line_done_q;
    assign Overrun      = overrun_q;

    // state register
    always_ff @(posedge MemClk) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // line geometry, fetch cursor and registered outputs
    always_ff @(posedge MemClk) begin
        if (!Reset) begin
            map_row_q   <= '0;
            delta_q     <= '0;
            tile_addr_q <= '0;
            row_q       <= '0;
            xoff_q      <= '0;
            tx_q        <= '0;
            w_q         <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            overrun_q   <= 1'b0;
            line_done_q <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            lb_wren_q   <= 1'b0;
            lb_addr_q   <= '0;
            lb_data_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            map_row_q   <= map_row_d;
            delta_q     <= delta_d;
            tile_addr_q <= tile_addr_d;
            row_q       <= row_d;
            xoff_q      <= xoff_d;
            tx_q        <= tx_d;
            w_q         <= w_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            overrun_q   <= overrun_d;
            line_done_q <= line_done_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            lb_wren_q   <= lb_wren_d;
            lb_addr_q   <= lb_addr_d;
            lb_data_q   <= lb_data_d;
            busy_q      <= busy_d;
        end
    end

    // next state: walk tiles and words; a LineStart restarts the walk, aborting any line in progress
    always_comb begin
        state_d     = state_q;
        map_row_d   = map_row_q;
        delta_d     = delta_q;
        tile_addr_d = tile_addr_q;
        row_d       = row_q;
        xoff_d      = xoff_q;
        tx_d        = tx_q;
        w_d         = w_q;
        idx_d       = idx_q;
        data_d      = data_q;
        overrun_d   = overrun_q;
        line_done_d = 1'b0;
        case (state_q)
            MAP_REQ:  if (Rd_Ack) state_d = MAP_WAIT;
            MAP_WAIT: if (Rd_Valid) begin
                idx_d   = Rd_Data[MAP_IDX_MSB:MAP_IDX_LSB];
                state_d = PIX_REQ;
            end
            PIX_REQ:  if (Rd_Ack) state_d = PIX_WAIT;
            PIX_WAIT: if (Rd_Valid) begin
                data_d  = Rd_Data;
                state_d = WR_LO;
            end
            WR_LO:    state_d = WR_HI;
            WR_HI: begin
                w_d = w_q + 1'b1;
                if (w_q != WORD_LAST) state_d = PIX_REQ;
                else if (tx_q != TX_LAST) begin
                    tx_d    = tx_q + 1'b1;
                    state_d = MAP_REQ;
                end else begin
                    state_d     = IDLE;
                    line_done_d = 1'b1;
                end
            end
            DRAIN:    if (Rd_Valid) state_d = MAP_REQ;
            default:  ;
        endcase
        if (LineStart) begin
            xoff_d = Xoffset;
            tx_d   = '0;
            w_d    = '0;
            if (LineNum == '0) begin
                map_row_d   = BaseAddress;
                delta_d     = DeltaAddress;
                tile_addr_d = TileAddress;
                row_d       = Yoffset;
            end else begin
                row_d     = row_q + 1'b1;
                map_row_d = (row_q == '1) ? map_row_q + ADDR_W'(delta_q) : map_row_q;
            end
            if (state_q == IDLE) state_d = MAP_REQ;
            else begin
                overrun_d   = 1'b1;
                line_done_d = 1'b0;
                state_d     = in_flight ? DRAIN : MAP_REQ;
            end
        end
    end

    // output flop inputs: read port follows the next state, line buffer follows the current write phase
    always_comb begin
        pix       = P_W'({tx_q, w_q, state_q == WR_HI});
        in_win    = pix >= P_W'(xoff_q) && pix < P_W'(xoff_q) + P_W'(H_PIXELS);
        rd_req_d  = state_d == MAP_REQ || state_d == PIX_REQ;
        rd_addr_d = state_d == MAP_REQ ? map_row_d + ADDR_W'(tx_d)
                  : state_d == PIX_REQ ? tile_addr_d | ADDR_W'({idx_d, row_d, w_d})
                  : rd_addr_q;
        lb_wren_d = (state_q == WR_LO || state_q == WR_HI) && !LineStart && in_win;
        lb_addr_d = lb_wren_d ? LB_AW'(pix - P_W'(xoff_q)) : lb_addr_q;
        lb_data_d = lb_wren_d ? (state_q == WR_HI ? data_q[15:8] : data_q[7:0]) : lb_data_q;
        busy_d    = state_d != IDLE || line_done_d;
    end
endmodule

// File: tb/tb_tile_line_fetcher.sv
// tb_tile_line_fetcher: scoreboard bench with a single-outstanding SDRAM responder model
module tb_tile_line_fetcher;
    localparam int H     = 640;
    localparam int TILES = H / 16 + 1;
    localparam int NRD   = TILES * 9;

    logic        MemClk = 1'b0;
    logic        Reset;
    logic [22:0] BaseAddress, TileAddress;
    logic [15:0] DeltaAddress;
    logic [3:0]  Xoffset, Yoffset;
    logic        LineStart;
    logic [9:0]  LineNum;
    logic        Rd_Req, Rd_Ack, Rd_Valid;
    logic [22:0] Rd_Address;
    logic [15:0] Rd_Data;
    logic        LB_wren, Busy, LineDone, Overrun;
    logic [9:0]  LB_wraddress;
    logic [7:0]  LB_data;

    tile_line_fetcher #(.H_PIXELS(H), .LB_AW(10)) dut (
        .MemClk(MemClk), .Reset(Reset),
        .BaseAddress(BaseAddress), .DeltaAddress(DeltaAddress), .TileAddress(TileAddress),
        .Xoffset(Xoffset), .Yoffset(Yoffset), .LineStart(LineStart), .LineNum(LineNum),
        .Rd_Req(Rd_Req), .Rd_Address(Rd_Address), .Rd_Ack(Rd_Ack), .Rd_Valid(Rd_Valid), .Rd_Data(Rd_Data),
        .LB_wren(LB_wren), .LB_wraddress(LB_wraddress), .LB_data(LB_data),
        .Busy(Busy), .LineDone(LineDone), .Overrun(Overrun)
    );

    always #5 MemClk = ~MemClk;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [logic [22:0]];
    logic [17:0] exp_wr [$];
    logic [22:0] exp_rd [$];
    logic [22:0] obs_rd [$];
    logic [22:0] b_map_row, b_tile;
    logic [15:0] b_delta;
    logic [3:0]  b_row;
    int          wr_cnt = 0;
    logic [17:0] first_wr, last_wr, mon_e;
    logic [22:0] rsp_e;
    int          valid_cnt = 0;
    int          ack_delay = 0;
    int          lat = 2;
    bit          inj_valid = 1'b0;
    bit          v_pend = 1'b0;
    int          v_cnt = 0;
    int          wait_cnt = 0;
    logic [15:0] v_data;

    function automatic logic [15:0] mem_rd(input logic [22:0] a);
        return mem.exists(a) ? mem[a] : (a[15:0] ^ 16'h5A3C);
    endfunction

    // SDRAM model: acks after ack_delay waiting cycles, returns data lat cycles after the ack
    initial begin
        Rd_Ack = 1'b0; Rd_Valid = 1'b0; Rd_Data = '0;
        forever begin
            @(posedge MemClk); #1;
            Rd_Ack = 1'b0; Rd_Valid = 1'b0;
            if (!Reset) begin
                v_pend = 1'b0; wait_cnt = 0;
            end else begin
                if (inj_valid) begin
                    Rd_Valid = 1'b1; Rd_Data = 16'hBEEF; inj_valid = 1'b0;
                end else if (v_pend && v_cnt == 1) begin
                    Rd_Valid = 1'b1; Rd_Data = v_data; v_pend = 1'b0; valid_cnt++;
                end else if (v_pend) v_cnt--;
                if (Rd_Req) begin
                    if (wait_cnt == ack_delay) begin
                        Rd_Ack = 1'b1; wait_cnt = 0;
                        v_pend = 1'b1; v_cnt = lat; v_data = mem_rd(Rd_Address);
                        obs_rd.push_back(Rd_Address);
                        checks++;
                        if (exp_rd.size() == 0) begin
                            errors++; $display("FAIL rd_addr: got %h, required no request", Rd_Address);
                        end else begin
                            rsp_e = exp_rd.pop_front();
                            if (Rd_Address !== rsp_e) begin
                                errors++; $display("FAIL rd_addr: got %h, required %h", Rd_Address, rsp_e);
                            end
                        end
                    end else wait_cnt++;
                end
            end
        end
    end

    // line buffer monitor: pop expected writes, and at LineDone require the line to be complete
    always @(negedge MemClk) begin
        if (LB_wren) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++; $display("FAIL lb_write: got addr=%0d data=%h, required no write", LB_wraddress, LB_data);
            end else begin
                mon_e = exp_wr.pop_front();
                if ({LB_wraddress, LB_data} !== mon_e) begin
                    errors++;
                    $display("FAIL lb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                             LB_wraddress, LB_data, mon_e[17:8], mon_e[7:0]);
                end
            end
            if (wr_cnt == 0) first_wr = {LB_wraddress, LB_data};
            last_wr = {LB_wraddress, LB_data};
            wr_cnt++;
        end
        if (LineDone) begin
            checks++;
            if (exp_wr.size() != 0 || exp_rd.size() != 0 || Busy !== 1'b1) begin
                errors++;
                $display("FAIL line_done: got pending wr=%0d rd=%0d busy=%b, required 0 0 1",
                         exp_wr.size(), exp_rd.size(), Busy);
            end
        end
    end

    task automatic build_expected(input logic [3:0] xo);
        logic [15:0] m, d;
        logic [22:0] a;
        int p;
        exp_wr.delete(); exp_rd.delete();
        for (int tx = 0; tx < TILES; tx++) begin
            a = b_map_row + 23'(tx);
            exp_rd.push_back(a);
            m = mem_rd(a);
            for (int w = 0; w < 8; w++) begin
                a = b_tile | {7'd0, m[8:0], b_row, 3'(w)};
                exp_rd.push_back(a);
                d = mem_rd(a);
                for (int b = 0; b < 2; b++) begin
                    p = tx * 16 + 2 * w + b;
                    if (p >= int'(xo) && p < int'(xo) + H)
                        exp_wr.push_back({10'(p - int'(xo)), (b == 1) ? d[15:8] : d[7:0]});
                end
            end
        end
    endtask

    task automatic start_line(input logic [9:0] ln, input logic [3:0] xo);
        if (ln == 0) begin
            b_map_row = BaseAddress; b_delta = DeltaAddress; b_tile = TileAddress; b_row = Yoffset;
        end else begin
            if (b_row == 4'hF) b_map_row = b_map_row + 23'(b_delta);
            b_row = b_row + 4'd1;
        end
        build_expected(xo);
        obs_rd.delete();
        wr_cnt = 0;
        @(posedge MemClk); #1;
        LineNum = ln; Xoffset = xo; LineStart = 1'b1;
        @(posedge MemClk); #1;
        LineStart = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge MemClk);
            if (LineDone) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        exp_wr.delete(); exp_rd.delete();
        LineStart = 1'b0;
        Reset = 1'b0;
        repeat (3) @(posedge MemClk);
        #1 Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        @(posedge MemClk); @(negedge MemClk);
        checks++;
        if ({Rd_Req, Rd_Address, LB_wren, LB_wraddress, LB_data, Busy, LineDone, Overrun} !== '0) begin
            errors++; $display("FAIL reset_values: got req=%b addr=%h wren=%b wa=%h d=%h busy=%b done=%b ovr=%b, required all 0",
                               Rd_Req, Rd_Address, LB_wren, LB_wraddress, LB_data, Busy, LineDone, Overrun);
        end
        #1 Reset = 1'b1;
    endtask

    task automatic test_basic_line();
        bit ok;
        do_reset();
        BaseAddress = 23'h000100; TileAddress = 23'h010000; DeltaAddress = 16'd0; Yoffset = 4'd0;
        mem[23'h000100] = 16'h0003;
        mem[23'h010180] = 16'h2211;
        start_line(10'd0, 4'd0);
        @(negedge MemClk);
        checks++;
        if (Busy !== 1'b1 || Rd_Req !== 1'b1 || Rd_Address !== 23'h000100) begin
            errors++; $display("FAIL basic_first_req: got busy=%b req=%b addr=%h, required 1 1 000100", Busy, Rd_Req, Rd_Address);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got no LineDone, required LineDone"); end
        @(negedge MemClk);
        checks++;
        if (wr_cnt != H) begin errors++; $display("FAIL basic_count: got %0d writes, required %0d", wr_cnt, H); end
        checks++;
        if (first_wr !== {10'd0, 8'h11}) begin errors++; $display("FAIL basic_first_wr: got %h, required %h", first_wr, {10'd0, 8'h11}); end
        checks++;
        if (obs_rd.size() != NRD || obs_rd[1] !== 23'h010180) begin
            errors++; $display("FAIL basic_pix_addr: got reads=%0d first_pix=%h, required %0d 010180", obs_rd.size(), obs_rd[1], NRD);
        end
        checks++;
        if (Busy !== 1'b0 || LineDone !== 1'b0 || Overrun !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got busy=%b done=%b ovr=%b, required 0 0 0", Busy, LineDone, Overrun);
        end
    endtask

    task automatic test_hscroll();
        bit ok;
        logic [15:0] m, d;
        start_line(10'd1, 4'd5);
        m = mem_rd(b_map_row);
        d = mem_rd(b_tile | {7'd0, m[8:0], b_row, 3'd2});
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL hscroll_done: got no LineDone, required LineDone"); end
        @(negedge MemClk);
        checks++;
        if (wr_cnt != H) begin errors++; $display("FAIL hscroll_count: got %0d writes, required %0d", wr_cnt, H); end
        checks++;
        if (first_wr !== {10'd0, d[15:8]}) begin errors++; $display("FAIL hscroll_first: got %h, required %h", first_wr, {10'd0, d[15:8]}); end
        checks++;
        if (last_wr[17:8] !== 10'd639) begin errors++; $display("FAIL hscroll_last: got addr %0d, required 639", last_wr[17:8]); end
    endtask

    task automatic test_vscroll();
        bit ok;
        logic [3:0]  rows [3] = '{4'd14, 4'd15, 4'd0};
        logic [22:0] maps [3] = '{23'h000300, 23'h000300, 23'h000340};
        logic [22:0] pa;
        do_reset();
        BaseAddress = 23'h000300; TileAddress = 23'h020000; DeltaAddress = 16'd64; Yoffset = 4'd14;
        for (int ln = 0; ln < 3; ln++) begin
            start_line(10'(ln), 4'd0);
            wait_done(ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL vscroll_done: line %0d got no LineDone, required LineDone", ln); end
            @(negedge MemClk);
            pa = (obs_rd.size() > 1) ? obs_rd[1] : '1;
            checks++;
            if (pa[6:3] !== rows[ln]) begin errors++; $display("FAIL vscroll_row: line %0d got %0d, required %0d", ln, pa[6:3], rows[ln]); end
            checks++;
            if (obs_rd.size() == 0 || obs_rd[0] !== maps[ln]) begin
                errors++; $display("FAIL vscroll_map: line %0d got %h, required %h", ln, (obs_rd.size() > 0) ? obs_rd[0] : '1, maps[ln]);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        logic [22:0] a0;
        ack_delay = 3;
        start_line(10'd3, 4'd0);
        @(negedge MemClk);
        a0 = Rd_Address;
        checks++;
        if (Rd_Req !== 1'b1 || a0 !== b_map_row) begin errors++; $display("FAIL stall_req: got req=%b addr=%h, required 1 %h", Rd_Req, a0, b_map_row); end
        for (int k = 1; k < 4; k++) begin
            @(negedge MemClk);
            checks++;
            if (Rd_Req !== 1'b1 || Rd_Address !== a0) begin
                errors++; $display("FAIL stall_hold: cycle %0d got req=%b addr=%h, required 1 %h", k, Rd_Req, Rd_Address, a0);
            end
        end
        @(negedge MemClk);
        checks++;
        if (Rd_Req !== 1'b0) begin errors++; $display("FAIL stall_release: got req=%b, required 0", Rd_Req); end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_done: got no LineDone, required LineDone"); end
        @(negedge MemClk);
        checks++;
        if (obs_rd.size() != NRD) begin errors++; $display("FAIL stall_reads: got %0d, required %0d", obs_rd.size(), NRD); end
        ack_delay = 0;
    endtask

    task automatic test_overrun();
        bit ok;
        bit seen;
        do_reset();
        BaseAddress = 23'h000200; TileAddress = 23'h030000; DeltaAddress = 16'd0; Yoffset = 4'd0;
        mem[23'h000200] = 16'hFE03;
        lat = 3;
        start_line(10'd0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge MemClk);
            seen = obs_rd.size() == 2;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL overrun_setup: got %0d reads, required 2", obs_rd.size()); end
        start_line(10'd1, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge MemClk);
            seen = Rd_Req;
        end
        checks++;
        if (!seen || Rd_Address !== 23'h000200) begin
            errors++; $display("FAIL overrun_map_req: got req=%b addr=%h, required 1 000200", seen, Rd_Address);
        end
        checks++;
        if (Overrun !== 1'b1 || wr_cnt != 0) begin
            errors++; $display("FAIL overrun_flag: got ovr=%b writes=%0d, required 1 0", Overrun, wr_cnt);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL overrun_done: got no LineDone, required LineDone"); end
        @(negedge MemClk);
        checks++;
        if (obs_rd.size() < 2 || obs_rd[1] !== 23'h030188) begin
            errors++; $display("FAIL overrun_idx: got %h, required 030188", (obs_rd.size() > 1) ? obs_rd[1] : '1);
        end
        checks++;
        if (Overrun !== 1'b1 || wr_cnt != H) begin
            errors++; $display("FAIL overrun_sticky: got ovr=%b writes=%0d, required 1 %0d", Overrun, wr_cnt, H);
        end
        lat = 2;
    endtask

    task automatic test_reset_mid();
        int vstart;
        bit seen;
        do_reset();
        BaseAddress = 23'h000100; TileAddress = 23'h010000; DeltaAddress = 16'd0; Yoffset = 4'd0;
        vstart = valid_cnt;
        start_line(10'd0, 4'd0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge MemClk);
            seen = valid_cnt == vstart + 2;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL reset_mid_setup: got %0d valids, required 2", valid_cnt - vstart); end
        exp_wr.delete(); exp_rd.delete();
        @(posedge MemClk); #1 Reset = 1'b0;
        @(posedge MemClk); #1 Reset = 1'b1;
        @(negedge MemClk);
        checks++;
        if ({Rd_Req, Rd_Address, LB_wren, LB_wraddress, LB_data, Busy, LineDone, Overrun} !== '0) begin
            errors++; $display("FAIL reset_mid_values: got req=%b addr=%h wren=%b wa=%h d=%h busy=%b done=%b ovr=%b, required all 0",
                               Rd_Req, Rd_Address, LB_wren, LB_wraddress, LB_data, Busy, LineDone, Overrun);
        end
        inj_valid = 1'b1;
        repeat (5) @(negedge MemClk);
        checks++;
        if (wr_cnt != 0 || Rd_Req !== 1'b0 || Busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ignore: got writes=%0d req=%b busy=%b, required 0 0 0", wr_cnt, Rd_Req, Busy);
        end
    endtask

    initial begin
        Reset = 1'b0; LineStart = 1'b0; LineNum = '0; Xoffset = '0; Yoffset = '0;
        BaseAddress = '0; TileAddress = '0; DeltaAddress = '0;
        test_reset();
        test_basic_line();
        test_hscroll();
        test_vscroll();
        test_stall();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
